// File: rtl/stage_mem_sram.sv
// MEM stage: runs LDR/STR as two 16-bit accesses to a single-port SRAM,
// freezes the upstream pipeline while an access is in flight, and holds the MEM/WB register.
module stage_mem_sram #(
   parameter int          WAIT_CYCLES = 3,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wbEnIn,
   input  logic               memREnIn,
   input  logic               memWEnIn,
   input  logic [31:0]        aluResIn,
   input  logic [31:0]        valRmIn,
   input  logic [3:0]         destIn,
   output logic               freeze,
   output logic               wbEnOut,
   output logic               memREnOut,
   output logic [31:0]        aluResOut,
   output logic [31:0]        memResOut,
   output logic [3:0]         destOut,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [15:0]         rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
   logic [SRAM_AW-1:0]  addr_q, addr_d;
   logic [15:0]         dq_q, dq_d;
   logic                we_n_q, we_n_d, oe_q, oe_d;
   logic                wb_q, wb_d, mr_q, mr_d;
   logic [31:0]         alu_q, alu_d, res_q, res_d;
   logic [3:0]          dest_q, dest_d;
   logic [31:0]         off;
   logic [SRAM_AW-2:0]  word;
   logic                last;
   logic                unused_ok;

   assign off       = aluResIn - BASE_ADDR;
   assign word      = off[SRAM_AW:2];
   assign unused_ok = ^{off[31:SRAM_AW+1], off[1:0]};
   assign last      = (cnt_q == CW'(WAIT_CYCLES - 1));
   assign freeze    = ((state_q == IDLE) && (memREnIn || memWEnIn)) ||
                      ((state_q != IDLE) && (state_q != DONE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_lo_d = rd_lo_q;
      rd_hi_d = rd_hi_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (memREnIn)      state_d = RD_LO;
            else if (memWEnIn) state_d = WR_LO;
         end
         RD_LO, RD_HI, WR_LO, WR_HI: begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               cnt_d = '0;
               case (state_q)
                  RD_LO: begin state_d = RD_HI; rd_lo_d = sram_dq_in; end
                  RD_HI: begin state_d = DONE;  rd_hi_d = sram_dq_in; end
                  WR_LO: state_d = WR_HI;
                  default: state_d = DONE;
               endcase
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // SRAM pins are registered from the next state so they line up with state_q.
      addr_d = '0;
      dq_d   = '0;
      we_n_d = 1'b1;
      oe_d   = 1'b0;
      case (state_d)
         RD_LO: addr_d = {word, 1'b0};
         RD_HI: addr_d = {word, 1'b1};
         WR_LO: begin addr_d = {word, 1'b0}; dq_d = valRmIn[15:0];  we_n_d = 1'b0; oe_d = 1'b1; end
         WR_HI: begin addr_d = {word, 1'b1}; dq_d = valRmIn[31:16]; we_n_d = 1'b0; oe_d = 1'b1; end
         default: ;
      endcase

      wb_d   = 1'b0;
      mr_d   = 1'b0;
      alu_d  = alu_q;
      res_d  = res_q;
      dest_d = dest_q;
      if (!freeze) begin
         wb_d   = wbEnIn;
         mr_d   = memREnIn;
         alu_d  = aluResIn;
         dest_d = destIn;
         if (memREnIn) res_d = {rd_hi_q, rd_lo_q};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_lo_q <= '0;
         rd_hi_q <= '0;
         addr_q  <= '0;
         dq_q    <= '0;
         we_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         wb_q    <= 1'b0;
         mr_q    <= 1'b0;
         alu_q   <= '0;
         res_q   <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_lo_q <= rd_lo_d;
         rd_hi_q <= rd_hi_d;
         addr_q  <= addr_d;
         dq_q    <= dq_d;
         we_n_q  <= we_n_d;
         oe_q    <= oe_d;
         wb_q    <= wb_d;
         mr_q    <= mr_d;
         alu_q   <= alu_d;
         res_q   <= res_d;
         dest_q  <= dest_d;
      end
   end

   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_q;
   assign sram_we_n   = we_n_q;
   assign sram_dq_oe  = oe_q;
   assign wbEnOut     = wb_q;
   assign memREnOut   = mr_q;
   assign aluResOut   = alu_q;
   assign memResOut   = res_q;
   assign destOut     = dest_q;

endmodule

// File: tb/tb_stage_mem_sram.sv
// Bench for stage_mem_sram: table of instructions driven through a timing model of the
// freeze protocol, an SRAM model, and a scoreboard of expected MEM/WB contents.
module tb_stage_mem_sram;
   localparam int W  = 3;
   localparam int AW = 18;

   logic clk = 1'b0, rst = 1'b0;
   logic wbEnIn = 0, memREnIn = 0, memWEnIn = 0;
   logic [31:0] aluResIn = '0, valRmIn = '0;
   logic [3:0]  destIn = '0;
   logic freeze, wbEnOut, memREnOut, sram_dq_oe, sram_we_n;
   logic [31:0] aluResOut, memResOut;
   logic [3:0]  destOut;
   logic [AW-1:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;

   stage_mem_sram #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .SRAM_AW(AW)) dut (
      .clk(clk), .rst(rst), .wbEnIn(wbEnIn), .memREnIn(memREnIn), .memWEnIn(memWEnIn),
      .aluResIn(aluResIn), .valRmIn(valRmIn), .destIn(destIn), .freeze(freeze),
      .wbEnOut(wbEnOut), .memREnOut(memREnOut), .aluResOut(aluResOut), .memResOut(memResOut),
      .destOut(destOut), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n));

   always #5 clk = ~clk;

   // SRAM model: asynchronous read, write on rising edge while we_n is low.
   logic [15:0] mem [0:1023];
   assign sram_dq_in = mem[sram_addr[9:0]];
   always @(posedge clk) begin
      if (!rst) begin
         mem[4]    <= 16'hBEEF;
         mem[5]    <= 16'hDEAD;
         mem[1022] <= 16'h3333;
         mem[1023] <= 16'h4444;
      end else if (!sram_we_n) begin
         mem[sram_addr[9:0]] <= sram_dq_out;
      end
   end

   typedef struct {
      logic wb; logic mr; logic [31:0] alu; logic [31:0] res; logic [3:0] dest;
   } wb_t;
   typedef struct {
      logic re; logic we; logic wb; logic [31:0] alu; logic [31:0] rm; logic [3:0] dest;
      logic [31:0] exp_res;
   } vec_t;

   wb_t q[$];
   wb_t prev;
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_wbEnOut", {31'b0, wbEnOut}, 0);
      chk("rst_memREnOut", {31'b0, memREnOut}, 0);
      chk("rst_aluResOut", aluResOut, 0);
      chk("rst_memResOut", memResOut, 0);
      chk("rst_destOut", {28'b0, destOut}, 0);
      chk("rst_we_n", {31'b0, sram_we_n}, 1);
      chk("rst_oe", {31'b0, sram_dq_oe}, 0);
      chk("rst_addr", {{(32-AW){1'b0}}, sram_addr}, 0);
      chk("rst_dq_out", {16'b0, sram_dq_out}, 0);
      chk("rst_freeze", {31'b0, freeze}, 0);
   endtask

   task automatic do_reset();
      rst = 0; wbEnIn = 0; memREnIn = 0; memWEnIn = 0;
      aluResIn = '0; valRmIn = '0; destIn = '0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk_reset_state();
      rst = 1;
      prev = '{1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
   endtask

   // Called at a falling edge; holds the instruction for the modelled freeze length.
   task automatic issue(input vec_t v, input int abort_at);
      int n;
      logic [31:0] off, e_addr;
      logic [16:0] word;
      logic e_we, e_oe, half;
      logic [15:0] e_dq;
      wb_t e, g;
      n = (v.re || v.we) ? 2*W+1 : 0;
      off = v.alu - 32'd1024;
      word = off[18:2];
      for (int j = 0; j <= n; j++) begin
         if (j == abort_at) begin
            do_reset();
            return;
         end
         wbEnIn = v.wb; memREnIn = v.re; memWEnIn = v.we;
         aluResIn = v.alu; valRmIn = v.rm; destIn = v.dest;
         #1;
         chk("freeze", {31'b0, freeze}, (j < n) ? 32'd1 : 32'd0);
         e_addr = '0; e_we = 1; e_oe = 0; e_dq = '0;
         if (j >= 1 && j <= 2*W) begin
            half = (j > W);
            e_addr = {13'b0, word, half};
            if (!v.re && v.we) begin
               e_we = 0; e_oe = 1;
               e_dq = half ? v.rm[31:16] : v.rm[15:0];
            end
         end
         chk("sram_addr", {{(32-AW){1'b0}}, sram_addr}, e_addr);
         chk("sram_we_n", {31'b0, sram_we_n}, {31'b0, e_we});
         chk("sram_dq_oe", {31'b0, sram_dq_oe}, {31'b0, e_oe});
         chk("sram_dq_out", {16'b0, sram_dq_out}, {16'b0, e_dq});
         if (j < n) e = '{1'b0, 1'b0, prev.alu, prev.res, prev.dest};
         else       e = '{v.wb, v.re, v.alu, v.re ? v.exp_res : prev.res, v.dest};
         prev = e;
         q.push_back(e);
         @(posedge clk); @(negedge clk);
         g = q.pop_front();
         chk("wbEnOut", {31'b0, wbEnOut}, {31'b0, g.wb});
         chk("memREnOut", {31'b0, memREnOut}, {31'b0, g.mr});
         chk("aluResOut", aluResOut, g.alu);
         chk("memResOut", memResOut, g.res);
         chk("destOut", {28'b0, destOut}, {28'b0, g.dest});
      end
   endtask

   vec_t vec [12];

   initial begin
      vec[0]  = '{0, 0, 1, 32'h55,       32'h0,        4'd3,  32'h0};        // plain ALU op
      vec[1]  = '{1, 0, 1, 32'd1032,     32'h0,        4'd5,  32'hDEADBEEF}; // preloaded load
      vec[2]  = '{0, 1, 0, 32'd1024,     32'h12345678, 4'd0,  32'h0};        // store word 0
      vec[3]  = '{1, 0, 1, 32'd1024,     32'h0,        4'd6,  32'h12345678}; // read it back
      vec[4]  = '{0, 1, 0, 32'd1040,     32'hCAFEF00D, 4'd1,  32'h0};        // store right after load
      vec[5]  = '{0, 0, 0, 32'hABCD,     32'h0,        4'd9,  32'h0};        // ALU op keeps memResOut
      vec[6]  = '{1, 1, 1, 32'd1040,     32'h11112222, 4'd2,  32'hCAFEF00D}; // both enables: read wins
      vec[7]  = '{1, 0, 1, 32'd1040,     32'h0,        4'd4,  32'hCAFEF00D}; // store was dropped
      vec[8]  = '{1, 0, 1, 32'd1020,     32'h0,        4'd8,  32'h44443333}; // below base wraps
      vec[9]  = '{1, 0, 1, 32'd1035,     32'h0,        4'd10, 32'hDEADBEEF}; // low addr bits ignored
      vec[10] = '{0, 1, 1, 32'd1048,     32'h0BADF00D, 4'd7,  32'h0};        // store with wbEn
      vec[11] = '{1, 0, 1, 32'd1048,     32'h0,        4'd11, 32'h0BADF00D};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 12; i++) issue(vec[i], -1);
      // Abort in the second cycle of RD_HI, then confirm normal traffic resumes.
      issue(vec[1], W + 2);
      issue('{0, 0, 1, 32'h77, 32'h0, 4'd12, 32'h0}, -1);
      issue(vec[3], -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
